// File: rtl/decode_stage.sv
// decode_stage: RISC-V instruction decode with a 2-entry skid buffer.
//   Decodes RV32I/RV64I base opcodes (plus M when ENABLE_M) into register
//   indices, immediate, funct fields, a one-hot class and qualifier flags.
//   All outputs are registered (latency 1); in_ready is a register.
// Ports:
//   clk, rst (sync, active-high), flush (drop all held entries)
//   in_valid/in_ready/in_inst/in_pc     upstream handshake
//   out_valid/out_ready/out_pc          downstream handshake
//   rs1_num, rs2_num, rd_num, imm, funct3, funct7, op_class, is_word,
//   is_muldiv, illegal                  decoded fields of presented entry
//   op_class one-hot {auipc,lui,jalr,jal,branch,load,store,op_imm,op}
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1_num,
  output logic [4:0]      rs2_num,
  output logic [4:0]      rd_num,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [8:0]      op_class,
  output logic            is_word,
  output logic            is_muldiv,
  output logic            illegal
);

  localparam bit RV64 = (XLEN == 64);

  typedef enum logic [6:0] {
    OPC_LOAD      = 7'h03,
    OPC_OP_IMM    = 7'h13,
    OPC_AUIPC     = 7'h17,
    OPC_OP_IMM_32 = 7'h1B,
    OPC_STORE     = 7'h23,
    OPC_OP        = 7'h33,
    OPC_LUI       = 7'h37,
    OPC_OP_32     = 7'h3B,
    OPC_BRANCH    = 7'h63,
    OPC_JALR      = 7'h67,
    OPC_JAL       = 7'h6F
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [8:0]      op_class;
    logic            is_word;
    logic            is_muldiv;
    logic            illegal;
  } entry_t;

  entry_t dec, out_q, skid_q;
  logic   skid_valid;
  logic   accept;

  logic fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
  logic bad, keep_f7, word, muldiv;
  logic [8:0] cls;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

  always_comb begin
    fmt_r   = 1'b0;
    fmt_i   = 1'b0;
    fmt_s   = 1'b0;
    fmt_b   = 1'b0;
    fmt_u   = 1'b0;
    fmt_j   = 1'b0;
    bad     = 1'b0;
    keep_f7 = 1'b0;
    word    = 1'b0;
    muldiv  = 1'b0;
    cls     = '0;
    case (in_inst[6:0])
      OPC_LOAD: begin
        fmt_i  = 1'b1;
        cls[3] = 1'b1;
        bad    = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OPC_OP_IMM: begin
        fmt_i   = 1'b1;
        cls[1]  = 1'b1;
        keep_f7 = (f3 == 3'b001) || (f3 == 3'b101);
      end
      OPC_OP_IMM_32: begin
        if (RV64) begin
          fmt_i   = 1'b1;
          cls[1]  = 1'b1;
          word    = 1'b1;
          keep_f7 = (f3 == 3'b001) || (f3 == 3'b101);
        end else begin
          bad = 1'b1;
        end
      end
      OPC_AUIPC: begin
        fmt_u  = 1'b1;
        cls[8] = 1'b1;
      end
      OPC_LUI: begin
        fmt_u  = 1'b1;
        cls[7] = 1'b1;
      end
      OPC_STORE: begin
        fmt_s  = 1'b1;
        cls[2] = 1'b1;
        bad    = RV64 ? (f3 > 3'b011) : (f3 > 3'b010);
      end
      OPC_OP, OPC_OP_32: begin
        if (in_inst[6:0] == OPC_OP_32 && !RV64) begin
          bad = 1'b1;
        end else begin
          fmt_r   = 1'b1;
          cls[0]  = 1'b1;
          keep_f7 = 1'b1;
          word    = (in_inst[6:0] == OPC_OP_32);
          if (ENABLE_M && f7 == 7'b0000001)
            muldiv = 1'b1;
          else if (!(f7 == 7'b0000000 ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
            bad = 1'b1;
        end
      end
      OPC_BRANCH: begin
        fmt_b  = 1'b1;
        cls[4] = 1'b1;
        bad    = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JALR: begin
        fmt_i  = 1'b1;
        cls[6] = 1'b1;
        bad    = (f3 != 3'b000);
      end
      OPC_JAL: begin
        fmt_j  = 1'b1;
        cls[5] = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    dec          = '0;
    dec.pc       = in_pc;
    dec.rd       = (fmt_r | fmt_i | fmt_u | fmt_j) ? in_inst[11:7]  : 5'd0;
    dec.rs1      = (fmt_r | fmt_i | fmt_s | fmt_b) ? in_inst[19:15] : 5'd0;
    dec.rs2      = (fmt_r | fmt_s | fmt_b)         ? in_inst[24:20] : 5'd0;
    dec.funct3   = (fmt_r | fmt_i | fmt_s | fmt_b) ? f3 : 3'd0;
    dec.funct7   = keep_f7 ? f7 : 7'd0;
    dec.illegal  = bad;
    if (!bad) begin
      dec.op_class  = cls;
      dec.is_word   = word;
      dec.is_muldiv = muldiv;
      if (fmt_i) dec.imm = imm_i;
      if (fmt_s) dec.imm = imm_s;
      if (fmt_b) dec.imm = imm_b;
      if (fmt_u) dec.imm = imm_u;
      if (fmt_j) dec.imm = imm_j;
    end
  end

  assign accept = in_valid & in_ready;

  // The skid only ever fills while the output is held; when the output is
  // free the skid entry (older) takes priority, and in_ready=0 guarantees no
  // new beat competes with it in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (out_valid && !out_ready) begin
      if (accept) begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
        in_ready   <= 1'b0;
      end
    end else if (skid_valid) begin
      out_q      <= skid_q;
      out_valid  <= 1'b1;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      if (accept) out_q <= dec;
      out_valid <= accept;
      in_ready  <= 1'b1;
    end
  end

  assign out_pc    = out_q.pc;
  assign rs1_num   = out_q.rs1;
  assign rs2_num   = out_q.rs2;
  assign rd_num    = out_q.rd;
  assign imm       = out_q.imm;
  assign funct3    = out_q.funct3;
  assign funct7    = out_q.funct7;
  assign op_class  = out_q.op_class;
  assign is_word   = out_q.is_word;
  assign is_muldiv = out_q.is_muldiv;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: three configurations (RV32, RV32+M,
// RV64+M) share one stimulus stream and are compared against a queue-based
// occupancy model and an arithmetic decode reference.
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  // a: XLEN=32 ENABLE_M=0, b: XLEN=32 ENABLE_M=1, c: XLEN=64 ENABLE_M=1
  logic        a_rdy, a_ov, a_w, a_m, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [2:0]  a_f3;
  logic [6:0]  a_f7;
  logic [8:0]  a_cls;
  logic        b_rdy, b_ov, b_w, b_m, b_ill;
  logic [31:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [2:0]  b_f3;
  logic [6:0]  b_f7;
  logic [8:0]  b_cls;
  logic        c_rdy, c_ov, c_w, c_m, c_ill;
  logic [63:0] c_pc, c_imm;
  logic [4:0]  c_rs1, c_rs2, c_rd;
  logic [2:0]  c_f3;
  logic [6:0]  c_f7;
  logic [8:0]  c_cls;

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(a_ov), .out_ready(out_ready),
    .out_pc(a_pc), .rs1_num(a_rs1), .rs2_num(a_rs2), .rd_num(a_rd), .imm(a_imm),
    .funct3(a_f3), .funct7(a_f7), .op_class(a_cls), .is_word(a_w),
    .is_muldiv(a_m), .illegal(a_ill));

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(b_ov), .out_ready(out_ready),
    .out_pc(b_pc), .rs1_num(b_rs1), .rs2_num(b_rs2), .rd_num(b_rd), .imm(b_imm),
    .funct3(b_f3), .funct7(b_f7), .op_class(b_cls), .is_word(b_w),
    .is_muldiv(b_m), .illegal(b_ill));

  decode_stage #(.XLEN(64), .ENABLE_M(1'b1)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_rdy),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(c_ov), .out_ready(out_ready),
    .out_pc(c_pc), .rs1_num(c_rs1), .rs2_num(c_rs2), .rd_num(c_rd), .imm(c_imm),
    .funct3(c_f3), .funct7(c_f7), .op_class(c_cls), .is_word(c_w),
    .is_muldiv(c_m), .illegal(c_ill));

  typedef struct {
    logic [63:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [8:0]  cls;
    logic        w, m, ill;
  } ref_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } beat_t;

  int    checks   = 0;
  int    failures = 0;
  beat_t q[$];
  bit    rdy_exp  = 1'b0;

  int    cfg_xlen[3] = '{32, 32, 64};
  bit    cfg_m[3]    = '{1'b0, 1'b1, 1'b1};
  string cfg_name[3] = '{"rv32", "rv32m", "rv64m"};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the ISA field definitions.
  function automatic ref_t ref_dec(input logic [31:0] i, input logic [63:0] pc,
                                   input int xlen, input bit em);
    ref_t        r;
    byte         fmt = "x";
    int          cbit = -1;
    bit          bad = 1'b0;
    bit          rv64 = (xlen == 64);
    logic [6:0]  opc = i[6:0];
    logic [2:0]  f3 = i[14:12];
    logic [6:0]  f7 = i[31:25];
    longint      v = 0;
    r = '{default: '0};
    r.pc = rv64 ? pc : {32'b0, pc[31:0]};
    case (opc)
      7'h03: begin fmt = "I"; cbit = 3; bad = (f3 == 7) || (!rv64 && (f3 == 3 || f3 == 6)); end
      7'h13: begin fmt = "I"; cbit = 1; if (f3 == 1 || f3 == 5) r.f7 = f7; end
      7'h1B: if (rv64) begin fmt = "I"; cbit = 1; r.w = 1; if (f3 == 1 || f3 == 5) r.f7 = f7; end
      7'h17: begin fmt = "U"; cbit = 8; end
      7'h37: begin fmt = "U"; cbit = 7; end
      7'h23: begin fmt = "S"; cbit = 2; bad = (f3 > (rv64 ? 3 : 2)); end
      7'h33, 7'h3B: if (opc == 7'h33 || rv64) begin
        fmt = "R"; cbit = 0; r.f7 = f7; r.w = (opc == 7'h3B);
        if (em && f7 == 7'd1) r.m = 1;
        else if (!(f7 == 0 || (f7 == 7'd32 && (f3 == 0 || f3 == 5)))) bad = 1;
      end
      7'h63: begin fmt = "B"; cbit = 4; bad = (f3 == 2 || f3 == 3); end
      7'h67: begin fmt = "I"; cbit = 6; bad = (f3 != 0); end
      7'h6F: begin fmt = "J"; cbit = 5; end
      default: ;
    endcase
    if (fmt == "x") bad = 1;
    if (fmt inside {"R", "I", "U", "J"}) r.rd  = i[11:7];
    if (fmt inside {"R", "I", "S", "B"}) begin r.rs1 = i[19:15]; r.f3 = f3; end
    if (fmt inside {"R", "S", "B"})      r.rs2 = i[24:20];
    case (fmt)
      "I": v = $signed(i[31:20]);
      "S": v = $signed({i[31:25], i[11:7]});
      "B": v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      "U": v = $signed(i) - $signed({20'b0, i[11:0]});
      "J": v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      default: v = 0;
    endcase
    r.ill = bad;
    if (bad) begin
      v = 0; r.w = 0; r.m = 0; r.cls = 0;
    end else begin
      r.cls = 9'(1 << cbit);
    end
    r.imm = rv64 ? 64'(v) : {32'b0, v[31:0]};
    return r;
  endfunction

  task automatic check_inst(input int k);
    ref_t  o, e;
    logic  ordy, oov;
    string n = cfg_name[k];
    case (k)
      0: begin ordy = a_rdy; oov = a_ov; o.pc = 64'(a_pc); o.imm = 64'(a_imm); o.rs1 = a_rs1;
               o.rs2 = a_rs2; o.rd = a_rd; o.f3 = a_f3; o.f7 = a_f7; o.cls = a_cls;
               o.w = a_w; o.m = a_m; o.ill = a_ill; end
      1: begin ordy = b_rdy; oov = b_ov; o.pc = 64'(b_pc); o.imm = 64'(b_imm); o.rs1 = b_rs1;
               o.rs2 = b_rs2; o.rd = b_rd; o.f3 = b_f3; o.f7 = b_f7; o.cls = b_cls;
               o.w = b_w; o.m = b_m; o.ill = b_ill; end
      default: begin ordy = c_rdy; oov = c_ov; o.pc = c_pc; o.imm = c_imm; o.rs1 = c_rs1;
               o.rs2 = c_rs2; o.rd = c_rd; o.f3 = c_f3; o.f7 = c_f7; o.cls = c_cls;
               o.w = c_w; o.m = c_m; o.ill = c_ill; end
    endcase
    chk({n, ".in_ready"}, 64'(ordy), 64'(rdy_exp));
    chk({n, ".out_valid"}, 64'(oov), 64'(q.size() > 0));
    if (q.size() > 0) begin
      e = ref_dec(q[0].inst, q[0].pc, cfg_xlen[k], cfg_m[k]);
      chk({n, ".pc"}, o.pc, e.pc);
      chk({n, ".imm"}, o.imm, e.imm);
      chk({n, ".rs1"}, 64'(o.rs1), 64'(e.rs1));
      chk({n, ".rs2"}, 64'(o.rs2), 64'(e.rs2));
      chk({n, ".rd"}, 64'(o.rd), 64'(e.rd));
      chk({n, ".funct3"}, 64'(o.f3), 64'(e.f3));
      chk({n, ".funct7"}, 64'(o.f7), 64'(e.f7));
      chk({n, ".op_class"}, 64'(o.cls), 64'(e.cls));
      chk({n, ".is_word"}, 64'(o.w), 64'(e.w));
      chk({n, ".is_muldiv"}, 64'(o.m), 64'(e.m));
      chk({n, ".illegal"}, 64'(o.ill), 64'(e.ill));
    end
  endtask

  // Drive one cycle, advance the occupancy model, then check all instances.
  task automatic step(input bit r, input bit fl, input bit v, input bit ordy,
                      input logic [31:0] inst, input logic [63:0] pc);
    bit acc;
    rst = r; flush = fl; in_valid = v; out_ready = ordy; in_inst = inst; in_pc = pc;
    @(posedge clk);
    if (r) begin
      q.delete(); rdy_exp = 1'b0;
    end else if (fl) begin
      q.delete(); rdy_exp = 1'b1;
    end else begin
      acc = v && rdy_exp;
      if (ordy && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back('{inst: inst, pc: pc});
      rdy_exp = (q.size() < 2);
    end
    #1;
    for (int k = 0; k < 3; k++) check_inst(k);
    if (r) begin
      chk("reset.a_imm", 64'(a_imm), 64'd0);
      chk("reset.c_pc", c_pc, 64'd0);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[11] = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                             7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F};
    logic [31:0] i = $urandom;
    int sel = $urandom_range(0, 12);
    if (sel < 11) i[6:0] = ops[sel];
    if (i[6:0] == 7'h33 || i[6:0] == 7'h3B)
      case ($urandom_range(0, 3))
        0: i[31:25] = 7'b0000000;
        1: i[31:25] = 7'b0100000;
        2: i[31:25] = 7'b0000001;
        default: ;
      endcase
    return i;
  endfunction

  initial begin
    logic [63:0] pc;
    // reset, with an input beat that must be ignored
    step(1, 0, 1, 1, 32'h00000013, 64'h100);
    step(1, 1, 1, 1, 32'h00000013, 64'h104);
    step(0, 0, 0, 1, 32'h0, 64'h0);
    chk("post_reset.in_ready", 64'(a_rdy), 64'd1);

    // addi x1,x2,-1
    step(0, 0, 1, 1, 32'hFFF10093, 64'h1000);
    chk("addi.rd", 64'(a_rd), 64'd1);
    chk("addi.rs1", 64'(a_rs1), 64'd2);
    chk("addi.imm", 64'(a_imm), 64'hFFFFFFFF);
    chk("addi.op_class", 64'(a_cls), 64'h002);
    // beq x0,x0,-4
    step(0, 0, 1, 1, 32'hFE000EE3, 64'h1004);
    chk("beq.imm", 64'(a_imm), 64'hFFFFFFFC);
    chk("beq.op_class", 64'(a_cls), 64'h010);
    // mul x3,x1,x2
    step(0, 0, 1, 1, 32'h022081B3, 64'h1008);
    chk("mul_nom.illegal", 64'(a_ill), 64'd1);
    chk("mul_nom.op_class", 64'(a_cls), 64'd0);
    chk("mul_m.is_muldiv", 64'(b_m), 64'd1);
    chk("mul_m.op_class", 64'(b_cls), 64'h001);
    chk("mul_m.rd", 64'(b_rd), 64'd3);
    // lui x5,0x80000 on RV64
    step(0, 0, 1, 1, 32'h800002B7, 64'hFFFF_0000_0000_100C);
    chk("lui64.imm", c_imm, 64'hFFFFFFFF80000000);
    chk("lui64.rd", 64'(c_rd), 64'd5);
    step(0, 0, 0, 1, 32'h0, 64'h0);

    // stall: A held, B into skid, C refused until the output drains
    step(0, 0, 1, 0, 32'h00100093, 64'h2000);
    step(0, 0, 1, 0, 32'h00200113, 64'h2004);
    chk("stall.in_ready_after_B", 64'(a_rdy), 64'd0);
    step(0, 0, 1, 0, 32'h00300193, 64'h2008);
    chk("stall.A_held", 64'(a_pc), 64'h2000);
    step(0, 0, 1, 1, 32'h00300193, 64'h2008);
    chk("stall.B_next", 64'(a_pc), 64'h2004);
    step(0, 0, 1, 0, 32'h00300193, 64'h2008);
    step(0, 0, 0, 1, 32'h0, 64'h0);
    chk("stall.C_last", 64'(a_pc), 64'h2008);
    step(0, 0, 0, 1, 32'h0, 64'h0);

    // flush with both entries full and a beat offered
    step(0, 0, 1, 0, 32'h00100093, 64'h3000);
    step(0, 0, 1, 0, 32'h00200113, 64'h3004);
    step(0, 1, 1, 1, 32'h00300193, 64'h3008);
    chk("flush.out_valid", 64'(c_ov), 64'd0);
    chk("flush.in_ready", 64'(c_rdy), 64'd1);
    step(0, 0, 0, 1, 32'h0, 64'h0);

    // reset mid-stall drops held entries
    step(0, 0, 1, 0, 32'h00100093, 64'h4000);
    step(0, 0, 1, 0, 32'h00200113, 64'h4004);
    step(1, 1, 1, 0, 32'h00300193, 64'h4008);
    step(0, 0, 0, 0, 32'h0, 64'h0);

    for (int n = 0; n < 600; n++) begin
      pc = {$urandom, $urandom};
      step($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_inst(), pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
